// File: rtl/reg_file_pkg.sv
// Shared types and default constants for the multi-port register file
// and its clear sequencer.
package reg_file_pkg;

    localparam int              DEF_DATA_WIDTH = 8;
    localparam int              DEF_ADDR_BITS  = 5;
    localparam logic [63:0]     DEF_CLEAR_VAL  = 64'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks clr_ptr over every entry once per sweep and
// drives the storage write port while a sweep is running.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr
);

    clr_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;

    // Next state: start on request, advance pointer, leave after last entry
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_BITS'(1);
                if (ptr_q == '1) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and pointer registers; reset always restarts a full sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy & ~rst;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with registered, write-first reads
// and a self-timed clear sweep after reset or on request.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_BITS  = DEF_ADDR_BITS,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = DATA_WIDTH'(DEF_CLEAR_VAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_BITS-1:0]  raddr_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic [ADDR_BITS-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] douta_q, douta_d;
    logic [DATA_WIDTH-1:0] doutb_q, doutb_d;

    logic                  clr_we;
    logic [ADDR_BITS-1:0]  clr_addr;
    logic                  usr_we;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    reg_file_clr_seq #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User writes are dropped during a sweep and while reset is held
    assign usr_we = wen & ~busy & ~rst;

    // Write port mux: sequencer owns the port whenever it is sweeping
    always_comb begin
        mem_we    = usr_we;
        mem_waddr = waddr;
        mem_wdata = data_in;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = CLEAR_VAL;
        end
    end

    // Storage array, no reset: contents are defined by the clear sweep
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read data select: sweep value, write-first bypass, or array
    always_comb begin
        douta_d = mem_q[raddr_a];
        doutb_d = mem_q[raddr_b];
        if (busy) begin
            douta_d = CLEAR_VAL;
            doutb_d = CLEAR_VAL;
        end else if (usr_we) begin
            if (raddr_a == waddr) douta_d = data_in;
            if (raddr_b == waddr) doutb_d = data_in;
        end
    end

    // Registered read ports
    always_ff @(posedge clk) begin
        if (rst) begin
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            douta_q <= douta_d;
            doutb_q <= doutb_d;
        end
    end

    assign data_out_a = douta_q;
    assign data_out_b = doutb_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default 8x32 instance plus a
// 16-bit, 8-entry instance with an all-ones clear value.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wen, clr_req, busy;
    logic [4:0] waddr, raddr_a, raddr_b;
    logic [7:0] data_in, doa, dob;

    logic        rst16, wen16, clr16, busy16;
    logic [2:0]  wa16, ra16, rb16;
    logic [15:0] di16, doa16, dob16;

    reg_file_mp dut8 (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .waddr      (waddr),
        .data_in    (data_in),
        .raddr_a    (raddr_a),
        .data_out_a (doa),
        .raddr_b    (raddr_b),
        .data_out_b (dob),
        .clr_req    (clr_req),
        .busy       (busy)
    );

    reg_file_mp #(
        .DATA_WIDTH (16),
        .ADDR_BITS  (3),
        .CLEAR_VAL  (16'hFFFF)
    ) dut16 (
        .clk        (clk),
        .rst        (rst16),
        .wen        (wen16),
        .waddr      (wa16),
        .data_in    (di16),
        .raddr_a    (ra16),
        .data_out_a (doa16),
        .raddr_b    (rb16),
        .data_out_b (dob16),
        .clr_req    (clr16),
        .busy       (busy16)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       nm;
        logic [15:0] ea;
        logic [15:0] eb;
        bit          wide;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        string      nm;
        logic       wen;
        logic [4:0] waddr;
        logic [7:0] din;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] ea,
                        input logic [15:0] eb, input bit wide);
        exp_t e;
        e.nm = nm; e.ea = ea; e.eb = eb; e.wide = wide;
        sbq.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.wide) begin
                check({e.nm, "_a"}, 32'(doa16), 32'(e.ea));
                check({e.nm, "_b"}, 32'(dob16), 32'(e.eb));
            end else begin
                check({e.nm, "_a"}, 32'(doa), 32'(e.ea));
                check({e.nm, "_b"}, 32'(dob), 32'(e.eb));
            end
        end
    endtask

    // Counts edges until busy falls; bounded
    task automatic sweep8(input string nm, input int exp_n);
        int n = 0;
        while (busy && n < 100) begin
            push({nm, "_busyout"}, 16'h0, 16'h0, 1'b0);
            step();
            n++;
        end
        check({nm, "_len"}, 32'(n), 32'(exp_n));
    endtask

    task automatic sweep16(input string nm, input int exp_n);
        int n = 0;
        while (busy16 && n < 100) begin
            push({nm, "_busyout"}, 16'hFFFF, 16'hFFFF, 1'b1);
            step();
            n++;
        end
        check({nm, "_len"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; clr_req = 1'b0;
        waddr = '0; data_in = '0; raddr_a = '0; raddr_b = '0;
        rst16 = 1'b1; wen16 = 1'b0; clr16 = 1'b0;
        wa16 = '0; di16 = '0; ra16 = '0; rb16 = '0;

        // Reset state
        push("rst_out", 16'h0, 16'h0, 1'b0);
        step();
        check("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        sweep8("init_sweep", 32);
        check("init_idle", 32'(busy), 32'd0);

        // Post-sweep reads return the clear value
        raddr_a = 5'd0; raddr_b = 5'd31;
        push("init_rd0", 16'h0, 16'h0, 1'b0);
        step();
        raddr_a = 5'd17; raddr_b = 5'd9;
        push("init_rd1", 16'h0, 16'h0, 1'b0);
        step();

        // Fill 10..41
        for (int i = 0; i < 32; i++) begin
            wen = 1'b1; waddr = 5'(i); data_in = 8'(i + 10);
            step();
        end
        wen = 1'b0;

        // Vector table: dual reads then bypass cases
        for (int i = 0; i < 32; i++) begin
            tbl.push_back('{"rd", 1'b0, 5'd0, 8'd0, 5'(i), 5'(31 - i),
                            8'(i + 10), 8'(41 - i)});
        end
        tbl.push_back('{"byp_both", 1'b1, 5'd7, 8'hA5, 5'd7, 5'd7,
                        8'hA5, 8'hA5});
        tbl.push_back('{"byp_commit", 1'b0, 5'd0, 8'd0, 5'd7, 5'd0,
                        8'hA5, 8'd10});
        tbl.push_back('{"byp_one", 1'b1, 5'd3, 8'h33, 5'd3, 5'd4,
                        8'h33, 8'd14});
        tbl.push_back('{"byp_commit2", 1'b0, 5'd0, 8'd0, 5'd3, 5'd3,
                        8'h33, 8'h33});

        foreach (tbl[k]) begin
            wen = tbl[k].wen; waddr = tbl[k].waddr;
            data_in = tbl[k].din;
            raddr_a = tbl[k].ra; raddr_b = tbl[k].rb;
            push(tbl[k].nm, 16'(tbl[k].ea), 16'(tbl[k].eb), 1'b0);
            step();
        end
        wen = 1'b0;

        // Requested sweep with a dropped write and a repeated request
        raddr_a = 5'd3; raddr_b = 5'd20;
        clr_req = 1'b1;
        push("clr_start", 16'h33, 16'd30, 1'b0);
        step();
        clr_req = 1'b0;
        begin
            int n = 0;
            while (busy && n < 100) begin
                n++;
                wen = (n == 5); waddr = 5'd3; data_in = 8'h55;
                clr_req = (n == 10);
                push("clr_busyout", 16'h0, 16'h0, 1'b0);
                step();
            end
            wen = 1'b0; clr_req = 1'b0;
            check("clr_len", 32'(n), 32'd32);
        end
        raddr_a = 5'd3; raddr_b = 5'd31;
        push("clr_rd3", 16'h0, 16'h0, 1'b0);
        step();

        // Reset mid-sweep restarts the pointer
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        push("midrst_out", 16'h0, 16'h0, 1'b0);
        step();
        rst = 1'b0;
        sweep8("midrst", 32);

        // Reset during a user write: reset wins, no bypass
        wen = 1'b1; waddr = 5'd5; data_in = 8'h77;
        raddr_a = 5'd5; raddr_b = 5'd5;
        rst = 1'b1;
        push("rstwr_out", 16'h0, 16'h0, 1'b0);
        step();
        rst = 1'b0; wen = 1'b0;
        sweep8("rstwr", 32);
        push("rstwr_rd5", 16'h0, 16'h0, 1'b0);
        step();

        // Wide, shallow instance
        push("w_rst_out", 16'h0, 16'h0, 1'b1);
        step();
        check("w_rst_busy", 32'(busy16), 32'd1);
        rst16 = 1'b0;
        sweep16("w_sweep", 8);
        ra16 = 3'd0; rb16 = 3'd7;
        push("w_rd_clr", 16'hFFFF, 16'hFFFF, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            wen16 = 1'b1; wa16 = 3'(i); di16 = 16'hA000 + 16'(i + 10);
            step();
        end
        wen16 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra16 = 3'(i); rb16 = 3'(7 - i);
            push("w_rd", 16'hA000 + 16'(i + 10),
                 16'hA000 + 16'(17 - i), 1'b1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
